// File: rtl/psum_adder_tree.sv
// Pipelined partial-sum reduction: registered binary adder tree, group accumulator with
// first-beat bias, and a saturating (or truncating) output stage with overflow flag.
module psum_adder_tree #(
    parameter int DATA_WID = 16,
    parameter int ICP_NUM  = 8,
    parameter int ACC_WID  = 24,
    parameter bit SAT_EN   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic [ICP_NUM*DATA_WID-1:0] data_in,
    input  logic signed [DATA_WID-1:0]  bias_in,
    output logic                        out_valid,
    output logic signed [DATA_WID-1:0]  data_out,
    output logic                        out_ovf
);

    localparam int LEVELS = $clog2(ICP_NUM);
    localparam logic signed [ACC_WID-1:0] MAX_A =
        {{(ACC_WID-DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
    localparam logic signed [ACC_WID-1:0] MIN_A =
        {{(ACC_WID-DATA_WID+1){1'b1}}, {(DATA_WID-1){1'b0}}};

    function automatic logic is_ovf(input logic signed [ACC_WID-1:0] a);
        return (a > MAX_A) || (a < MIN_A);
    endfunction

    function automatic logic signed [DATA_WID-1:0] sat_trunc(input logic signed [ACC_WID-1:0] a);
        if (SAT_EN && (a > MAX_A)) return MAX_A[DATA_WID-1:0];
        if (SAT_EN && (a < MIN_A)) return MIN_A[DATA_WID-1:0];
        return a[DATA_WID-1:0];
    endfunction

    // Stage p0: sign-extended leaves. The tree is a heap: node i = node 2i + node 2i+1,
    // where indices >= ICP_NUM are leaves, so every heap depth is one register level.
    logic signed [ACC_WID-1:0] leaf_p0 [ICP_NUM];
    logic signed [ACC_WID-1:0] lhs     [1:ICP_NUM-1];
    logic signed [ACC_WID-1:0] rhs     [1:ICP_NUM-1];
    logic signed [ACC_WID-1:0] tree_p  [1:ICP_NUM-1];

    for (genvar i = 0; i < ICP_NUM; i++) begin : g_leaf
        assign leaf_p0[i] = {{(ACC_WID-DATA_WID){data_in[i*DATA_WID+DATA_WID-1]}},
                             data_in[i*DATA_WID +: DATA_WID]};
    end

    for (genvar i = 1; i < ICP_NUM; i++) begin : g_node
        if (2*i >= ICP_NUM) begin : g_from_leaf
            assign lhs[i] = leaf_p0[2*i-ICP_NUM];
            assign rhs[i] = leaf_p0[2*i+1-ICP_NUM];
        end else begin : g_from_node
            assign lhs[i] = tree_p[2*i];
            assign rhs[i] = tree_p[2*i+1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < ICP_NUM; i++) begin
            if (reset) tree_p[i] <= '0;
            else       tree_p[i] <= lhs[i] + rhs[i];
        end
    end

    // Control and bias travel alongside the tree levels.
    logic [LEVELS-1:0]          vld_p;
    logic [LEVELS-1:0]          first_p;
    logic [LEVELS-1:0]          last_p;
    logic signed [DATA_WID-1:0] bias_p [LEVELS];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p   <= '0;
            first_p <= '0;
            last_p  <= '0;
            for (int k = 0; k < LEVELS; k++) bias_p[k] <= '0;
        end else begin
            vld_p[0]   <= in_valid;
            first_p[0] <= in_first;
            last_p[0]  <= in_last;
            bias_p[0]  <= bias_in;
            for (int k = 1; k < LEVELS; k++) begin
                vld_p[k]   <= vld_p[k-1];
                first_p[k] <= first_p[k-1];
                last_p[k]  <= last_p[k-1];
                bias_p[k]  <= bias_p[k-1];
            end
        end
    end

    // Accumulator stage: wraps modulo 2^ACC_WID, holds through bubbles.
    logic signed [ACC_WID-1:0] bias_ext;
    logic signed [ACC_WID-1:0] acc_p;
    logic                      done_p;

    assign bias_ext = {{(ACC_WID-DATA_WID){bias_p[LEVELS-1][DATA_WID-1]}}, bias_p[LEVELS-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p  <= '0;
            done_p <= 1'b0;
        end else begin
            done_p <= vld_p[LEVELS-1] & last_p[LEVELS-1];
            if (vld_p[LEVELS-1]) begin
                if (first_p[LEVELS-1]) acc_p <= bias_ext + tree_p[1];
                else                   acc_p <= acc_p + tree_p[1];
            end
        end
    end

    // Output stage: result and overflow flag held until the next completed group.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= done_p;
            if (done_p) begin
                data_out <= sat_trunc(acc_p);
                out_ovf  <= is_ovf(acc_p);
            end
        end
    end

endmodule
